// File: rtl/nibble_accum.sv
// nibble_accum: 8-bit running-total accumulator fed with 4-bit operands.
// A single 4-bit ripple adder (no carry-in) is reused for two passes per
// operand: the low nibble pass adds the operand, the high nibble pass folds
// in the carry from the low pass.
//
// Handshake: an operand transfers on a rising edge where in_valid && in_ready;
// in_ready is high only in IDLE while clear is low, so clear always wins over
// a pending operand. out_valid is a one-cycle pulse in DONE marking a fresh acc.

module ripple4adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] sum,
   output logic       carry
);

   logic [4:0] w_c;

   assign w_c[0] = 1'b0;

   for (genvar i = 0; i < 4; i++) begin : g_bit
      assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
   end

   assign carry = w_c[4];

endmodule

module nibble_accum (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [3:0] in_data,
   output logic       in_ready,
   input  logic       clear,
   output logic [7:0] acc,
   output logic       out_valid,
   output logic       overflow,
   output logic [3:0] count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LO   = 2'd1,
      S_HI   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_next_state;

   logic [3:0] r_op;
   logic       r_carry;
   logic [7:0] r_acc;
   logic       r_ovf;
   logic [3:0] r_count;

   logic       w_hs;
   logic [3:0] w_add_a;
   logic [3:0] w_add_b;
   logic [3:0] w_add_sum;
   logic       w_add_carry;

   // Shared adder: operands selected by the current pass
   ripple4adder u_add (
      .a     (w_add_a),
      .b     (w_add_b),
      .sum   (w_add_sum),
      .carry (w_add_carry)
   );

   assign w_hs = in_valid && in_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: only IDLE waits, the passes advance unconditionally
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_hs) w_next_state = S_LO;
         S_LO:    w_next_state = S_HI;
         S_HI:    w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Outputs and adder operand selection decoded from state
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      w_add_a   = r_acc[3:0];
      w_add_b   = r_op;
      case (r_state)
         S_IDLE: in_ready = ~clear;
         S_HI: begin
            w_add_a = r_acc[7:4];
            w_add_b = {3'b000, r_carry};
         end
         S_DONE: out_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath: operand capture, clear, and the two nibble write-backs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op    <= 4'h0;
         r_carry <= 1'b0;
         r_acc   <= 8'h00;
         r_ovf   <= 1'b0;
         r_count <= 4'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (clear) begin
                  r_acc   <= 8'h00;
                  r_ovf   <= 1'b0;
                  r_count <= 4'h0;
               end else if (w_hs) begin
                  r_op <= in_data;
                  if (r_count != 4'hF) begin
                     r_count <= r_count + 4'h1;
                  end
               end
            end
            S_LO: begin
               r_acc[3:0] <= w_add_sum;
               r_carry    <= w_add_carry;
            end
            S_HI: begin
               r_acc[7:4] <= w_add_sum;
               r_ovf      <= r_ovf | w_add_carry;
            end
            default: ;
         endcase
      end
   end

   assign acc      = r_acc;
   assign overflow = r_ovf;
   assign count    = r_count;

endmodule

// File: tb/tb_nibble_accum.sv
// Directed + randomized bench for nibble_accum. The reference model keeps the
// running total as a plain integer sum, derives overflow from sum > 255 and
// counts operands with a saturating integer.

module tb_nibble_accum;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic       clear;
   logic [7:0] acc;
   logic       out_valid;
   logic       overflow;
   logic [3:0] count;

   int n_checks;
   int n_pass;
   int cyc;
   int cur_done;
   int prev_done;

   int m_total;
   logic [7:0] m_acc;
   logic       m_ovf;
   int m_cnt;

   nibble_accum dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .clear     (clear),
      .acc       (acc),
      .out_valid (out_valid),
      .overflow  (overflow),
      .count     (count)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle counter for latency/throughput checks
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         $display("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
         $error("%s observed=0x%02h expected=0x%02h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_total = 0;
      m_acc   = 8'h00;
      m_ovf   = 1'b0;
      m_cnt   = 0;
   endtask

   task automatic model_add(input logic [3:0] d);
      m_total = int'(m_acc) + int'(d);
      if (m_total > 255) m_ovf = 1'b1;
      m_acc = 8'(m_total % 256);
      if (m_cnt < 15) m_cnt = m_cnt + 1;
   endtask

   // Asynchronous reset pulse placed between clock edges, checked before any edge
   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_acc", acc, 8'h00);
      chk("rst_ovf", {7'b0, overflow}, 8'h00);
      chk("rst_cnt", {4'b0, count}, 8'h00);
      chk("rst_ov", {7'b0, out_valid}, 8'h00);
      #1 rst = 1'b0;
      #0;
      chk("rst_rdy", {7'b0, in_ready}, 8'h01);
      model_reset();
   endtask

   // One operand: IDLE -> LO -> HI -> DONE; returns at the DONE cycle's negedge
   task automatic do_op(input logic [3:0] d, input logic clr_hi);
      @(negedge clk);
      chk("idle_rdy", {7'b0, in_ready}, 8'h01);
      chk("idle_ov", {7'b0, out_valid}, 8'h00);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      model_add(d);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 4'($urandom_range(0, 15));
      chk("lo_rdy", {7'b0, in_ready}, 8'h00);
      chk("lo_ov", {7'b0, out_valid}, 8'h00);
      chk("lo_cnt", {4'b0, count}, 8'(m_cnt));
      @(negedge clk);
      clear    = clr_hi;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 4'($urandom_range(0, 15));
      chk("hi_ov", {7'b0, out_valid}, 8'h00);
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("done_ov", {7'b0, out_valid}, 8'h01);
      chk("done_acc", acc, m_acc);
      chk("done_ovf", {7'b0, overflow}, {7'b0, m_ovf});
      chk("done_cnt", {4'b0, count}, 8'(m_cnt));
      prev_done = cur_done;
      cur_done  = cyc;
   endtask

   // Stimulus
   initial begin
      logic [3:0] seq [10];
      logic [3:0] r;
      n_checks  = 0;
      n_pass    = 0;
      cur_done  = 0;
      prev_done = 0;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = 4'h0;
      clear     = 1'b0;
      model_reset();

      // Power-up reset and reset-state checks
      do_reset();

      // Two operands, back to back
      do_op(4'h2, 1'b0);
      chk("seq23_a", acc, 8'h02);
      do_op(4'h3, 1'b0);
      chk("seq23_b", acc, 8'h05);
      chk("seq23_cnt", {4'b0, count}, 8'h02);
      chk("seq23_thru", 8'(cur_done - prev_done), 8'h04);

      // Low-nibble carry into high nibble
      do_reset();
      do_op(4'hF, 1'b0);
      chk("nc_a", acc, 8'h0F);
      do_op(4'h1, 1'b0);
      chk("nc_b", acc, 8'h10);
      chk("nc_ovf", {7'b0, overflow}, 8'h00);

      // Wrap past 0xFF and count saturation
      do_reset();
      for (int i = 0; i < 17; i++) do_op(4'hF, 1'b0);
      chk("wrap_pre_acc", acc, 8'hFF);
      chk("wrap_pre_ovf", {7'b0, overflow}, 8'h00);
      chk("wrap_pre_cnt", {4'b0, count}, 8'h0F);
      do_op(4'h1, 1'b0);
      chk("wrap_acc", acc, 8'h00);
      chk("wrap_ovf", {7'b0, overflow}, 8'h01);
      chk("wrap_cnt", {4'b0, count}, 8'h0F);
      do_op(4'h2, 1'b0);
      chk("wrap_sticky_acc", acc, 8'h02);
      chk("wrap_sticky_ovf", {7'b0, overflow}, 8'h01);

      // Ten-operand sequence, clear during HI of the last one is ignored
      do_reset();
      seq = '{4'h2, 4'h3, 4'h4, 4'h7, 4'h5, 4'hA, 4'h6, 4'hE, 4'hD, 4'h9};
      for (int i = 0; i < 10; i++) do_op(seq[i], (i == 9));
      chk("seq10_acc", acc, 8'h49);
      chk("seq10_ovf", {7'b0, overflow}, 8'h00);
      chk("seq10_cnt", {4'b0, count}, 8'h0A);

      // Clear together with in_valid in IDLE: clear wins, nothing accepted
      @(negedge clk);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 4'h5;
      #0;
      chk("clr_rdy", {7'b0, in_ready}, 8'h00);
      @(negedge clk);
      chk("clr_acc", acc, 8'h00);
      chk("clr_cnt", {4'b0, count}, 8'h00);
      chk("clr_ov", {7'b0, out_valid}, 8'h00);
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      #0;
      chk("clr_idle_rdy", {7'b0, in_ready}, 8'h01);
      @(negedge clk);
      chk("clr_noacc_cnt", {4'b0, count}, 8'h00);
      chk("clr_noacc_ov", {7'b0, out_valid}, 8'h00);
      model_reset();

      // Randomized operands against the model
      for (int i = 0; i < 40; i++) begin
         r = 4'($urandom_range(0, 15));
         do_op(r, 1'($urandom_range(0, 1)));
      end
      // Clear after a long run drops overflow and count too
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("rclr_acc", acc, 8'h00);
      chk("rclr_ovf", {7'b0, overflow}, 8'h00);
      chk("rclr_cnt", {4'b0, count}, 8'h00);
      model_reset();

      // Reset during HI abandons the operand
      do_reset();
      do_op(4'hF, 1'b0);
      chk("mid_pre_acc", acc, 8'h0F);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 4'h9;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_acc", acc, 8'h00);
      chk("mid_ov", {7'b0, out_valid}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mid_post_ov", {7'b0, out_valid}, 8'h00);
         chk("mid_post_rdy", {7'b0, in_ready}, 8'h01);
         chk("mid_post_acc", acc, 8'h00);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
